// File: rtl/alu_muldiv.sv
// Iterative RV32M-style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with valid/ready handshake and flush.
module alu_muldiv #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d, dz_q, dz_d;

  logic               sgn_a, sgn_b, neg_a, neg_b, dz_in, ovf_in;
  logic [WIDTH-1:0]   abs_a, abs_b, early_res;

  always_comb begin
    sgn_a     = op[2] ? ~op[0] : (op[1:0] == 2'd1 || op[1:0] == 2'd2);
    sgn_b     = op[2] ? ~op[0] : (op[1:0] == 2'd1);
    neg_a     = sgn_a & dataa[WIDTH-1];
    neg_b     = sgn_b & datab[WIDTH-1];
    abs_a     = neg_a ? -dataa : dataa;
    abs_b     = neg_b ? -datab : datab;
    dz_in     = op[2] && (datab == '0);
    ovf_in    = op[2] && !op[0] && (dataa == MIN_VAL) && (&datab);
    early_res = dz_in ? (op[1] ? dataa : '1) : (op[1] ? '0 : MIN_VAL);
  end

  // acc holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, acc_n, prod;
  logic [WIDTH-1:0]   quo_rem, fin_res;
  logic               fin_dz;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, b_q} & {(WIDTH+1){acc_q[0]}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    acc_n    = op_q[2] ? div_next : mul_next;
    prod     = neg_q ? -acc_n : acc_n;
    quo_rem  = op_q[1] ? acc_n[2*WIDTH-1:WIDTH] : acc_n[WIDTH-1:0];
    fin_dz   = op_q[2] && (b_q == '0);
    if (!op_q[2])
      fin_res = (op_q[1:0] == 2'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    else if (fin_dz)
      fin_res = op_q[1] ? a_q : '1;
    else
      fin_res = neg_q ? -quo_rem : quo_rem;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    dz_d     = dz_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d  = op;
            a_d   = dataa;
            b_d   = abs_b;
            acc_d = {{WIDTH{1'b0}}, abs_a};
            neg_d = (op[2] && op[1]) ? neg_a : (neg_a ^ neg_b);
            cnt_d = '0;
            if (EARLY_OUT && (dz_in || ovf_in)) begin
              state_d  = S_DONE;
              result_d = early_res;
              dz_d     = dz_in;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = acc_n;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            result_d = fin_res;
            dz_d     = fin_dz;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv (WIDTH=32, EARLY_OUT=1): directed vectors, random ops
// against an arithmetic reference model, backpressure, flush and async reset.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] dataa = 32'd0;
  logic [31:0] datab = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        div_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] MINV = 32'h8000_0000;

  alu_muldiv #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .dataa(dataa), .datab(datab),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {div_zero, result} straight from the RV32M arithmetic rules
  function automatic logic [32:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sb; return {1'b0, p[31:0]}; end
      3'd1: begin p = sa * sb; return {1'b0, p[63:32]}; end
      3'd2: begin p = sa * longint'({32'd0, b}); return {1'b0, p[63:32]}; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p[63:32]}; end
      3'd4: begin
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF};
        p = sa / sb;
        return {1'b0, p[31:0]};
      end
      3'd5: begin
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, a / b};
      end
      3'd6: begin
        if (b == 32'd0) return {1'b1, a};
        p = sa % sb;
        return {1'b0, p[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a};
        return {1'b0, a % b};
      end
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [32:0] e;
    int          n;
    int          exp_lat;
    logic        busy_bad;
    e        = ref_model(o, a, b);
    exp_lat  = (o[2] && (b == 32'd0 || (!o[0] && a == MINV && b == 32'hFFFF_FFFF))) ? 0 : 32;
    busy_bad = 1'b0;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; dataa = a; datab = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); dataa = $urandom; datab = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) busy_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("busy_calc", 32'(busy_bad), 32'd0);
    check("result", result, e[31:0]);
    check("div_zero", 32'(div_zero), 32'(e[32]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", result, e[31:0]);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int   seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #20 rst_n = 1'b1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    do_op(3'd1, MINV, MINV, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd5, 32'd100, 32'd7, 0);
    do_op(3'd7, 32'd100, 32'd7, 0);
    do_op(3'd5, 32'd5, 32'd0, 0);
    do_op(3'd6, 32'd5, 32'd0, 0);
    do_op(3'd4, MINV, 32'hFFFF_FFFF, 0);
    do_op(3'd6, MINV, 32'hFFFF_FFFF, 0);
    do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5);

    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
      if ($urandom_range(0, 9) == 0) ra = MINV;
      do_op(ro, ra, rb, int'($urandom_range(0, 2)));
    end

    // flush at CALC cycle 10 with a competing request
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; dataa = 32'd3; datab = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'd5; dataa = 32'd9; datab = 32'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    check("flush_quiet", 32'(seen), 32'd0);

    // async reset mid-CALC
    do_op(3'd7, 32'd77, 32'd10, 0);
    @(negedge clk);
    in_valid = 1'b1; op = 3'd3; dataa = 32'hFFFF_0000; datab = 32'h0000_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_div_zero", 32'(div_zero), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("rst_quiet", 32'(seen), 32'd0);
    do_op(3'd4, 32'hFFFF_FF9C, 32'd7, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M operation set; sits beside the single-cycle integer ALU in EX.
- Pipeline stalls on in_ready/out_valid.
- Generalises operand width to WIDTH and adds a valid/ready handshake, multi-cycle iteration, special-case early-out and flush.

Parameters:
WIDTH, 32, operand/result width in bits; must be even and >= 8
EARLY_OUT, 1, 1 = divide-by-zero and signed overflow complete without iterating; 0 = always iterate

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  abort current operation (pipeline flush)
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
dataa  in  WIDTH  rs1 operand
datab  in  WIDTH  rs2 operand
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  operation result
div_zero  out  1  valid with out_valid: div/rem op had datab==0
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; result=0; div_zero=0; busy=0; iteration counter=0.
- States:
  - IDLE: in_ready=1.
  - CALC: iterating, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Transitions:
  - IDLE -> CALC on in_valid (accept edge E). Latch op and operands; take absolute values per signedness; counter=0.
  - IDLE -> DONE directly, skipping CALC, when EARLY_OUT=1 and either:
    - div/rem op with datab==0; or
    - DIV/REM with dataa = most-negative and datab = all ones.
  - CALC: one iteration per cycle.
    - Multiply: radix-2 shift-add over a 2*WIDTH product register.
    - Divide: restoring shift-subtract.
    - Counter increments each cycle. After exactly WIDTH iterations (edge E+WIDTH) go to DONE with sign-corrected result registered. out_valid first high in the cycle after edge E+WIDTH; latency = WIDTH cycles.
  - DONE -> IDLE on out_ready. result/div_zero hold stable while out_valid && !out_ready.
- Results (WIDTH-bit, two's complement):
  - MUL: low half of product.
  - MULH: high half, signed x signed.
  - MULHSU: high half, signed dataa x unsigned datab.
  - MULHU: high half, unsigned x unsigned.
  - DIV/DIVU: quotient truncated toward zero.
  - REM/REMU: remainder takes sign of dividend.
- Divide by zero: quotient = all ones (DIV and DIVU); remainder = dataa; div_zero=1. Identical result with EARLY_OUT=0 (fixed up at final edge).
- Signed overflow (MIN / -1): DIV returns MIN; REM returns 0; div_zero=0.
- div_zero=0 for all multiply ops.
- flush: highest priority in every state.
  - Next edge state=IDLE, out_valid=0, counter=0.
  - A request presented with in_valid in the same cycle as flush is NOT accepted.
  - A pending DONE result is discarded.
- Operands are sampled only on the accept edge; dataa/datab/op changes during CALC have no effect.
- No back-to-back accept in the DONE->IDLE cycle: at most one request per WIDTH+1 cycles when iterating.
- Reset asserted mid-CALC/DONE: immediate return to reset values; no partial result emitted.

Test Plan:
- WIDTH=32, MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB. out_valid first high exactly 32 cycles after accept edge; busy high throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF with div_zero=1, and REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0. With EARLY_OUT=1, out_valid is high in the cycle after accept.
- Backpressure: out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0. Raise out_ready -> IDLE next edge, in_ready=1.
- Flush at CALC cycle 10 with in_valid=1 in the same cycle -> IDLE next edge, no out_valid ever, request not accepted. Repeat with rst_n pulsed low mid-CALC -> all outputs at reset values immediately.
